seq_shifter: RTL and testbench
==============================

# seq_shifter

Parametrised multi-cycle shift/rotate unit for the datapath, the successor to the fixed single-step shifter. It holds a WIDTH-bit data register and a carry bit, and executes a shift or rotate of 0..2^CNT_W-1 positions under a start/busy/done handshake. It supports four rotate modes, three shift modes and a status flag vector. It sits beside the ALU and is loaded and read by the controller.

## Interface
- WIDTH, 16: data register width (≥4)
- CNT_W, 5: shift-amount width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous reset, active-high
- ld  in  1  load data register from d (IDLE only)
- ldc  in  1  load carry from cin (IDLE only)
- d  in  WIDTH  load data
- cin  in  1  load carry value
- start  in  1  begin operation (IDLE only)
- op  in  3  operation code, sampled with start
- amt  in  CNT_W  shift count, sampled with start
- q  out  WIDTH  data register
- cn  out  1  carry register
- busy  out  1  high in SHIFT state
- done  out  1  one-cycle pulse, operation complete
- flag  out  4  {parity(^q), n(q[WIDTH-1]), z(q==0), cn}, combinational from registers

## Operation
- Ops, per single step:
  - 000 ROL: MSB→LSB, cn←old MSB
  - 001 RCL: rotate through {cn,q}, cn←old MSB, LSB←old cn
  - 010 ROR: LSB→MSB, cn←old LSB
  - 011 RCR: MSB←old cn, cn←old LSB
  - 100 SHL: LSB←0, cn←old MSB
  - 101 SHR: MSB←0, cn←old LSB
  - 110 SAR: MSB kept, cn←old LSB
  - 111: no-op; q/cn unchanged, handshake still completes
- FSM IDLE/SHIFT/DONE.
- IDLE:
  - ld: q←d. ldc: cn←cin. Both allowed in the same cycle.
  - start with ld or ldc asserted: loads happen, start dropped.
  - start, amt==0 or op==111: →DONE, no data change.
  - start, otherwise: latch op, cnt←amt, →SHIFT.
- SHIFT: one step per cycle, cnt decrements; step with cnt==1 →DONE. start/ld/ldc ignored.
- DONE: done=1 for one cycle, →IDLE. Inputs ignored.
- amt ≥ WIDTH is legal:
  - Rotates wrap naturally (period WIDTH for ROL/ROR, WIDTH+1 for RCL/RCR).
  - SHL/SHR: q=0; cn=0 if amt>WIDTH.
  - SAR: q and cn = sign fill.
- Reset values: q=0, cn=0, busy=0, done=0, state IDLE; flag=4'b0010.
- rst mid-operation: immediate abort to reset values, no done pulse.

## Timing
- start sampled at edge E0.
- amt=k>0: steps at edges E1..Ek. busy high from after E0 through Ek. Final q valid and done high after Ek. IDLE after Ek+1.
- amt=0 / op=111: done high after E0, IDLE after E1.
- Next start accepted one cycle after done (back-to-back interval k+2).
- ld/ldc take effect at the edge they are sampled; q visible the next cycle.

## Configuration
- SEQ_SHIFTER_BARREL_EN:
  - Defined: SHIFT lasts exactly one cycle and applies the full amt-position result combinationally (barrel network). Results, including cn and amt ≥ WIDTH cases, are bit-identical to iterative mode. done is high after E1 for every amt>0.
  - Undefined: iterative one-bit-per-cycle datapath as above, no barrel logic.

## Test plan
- Reset mid-SHIFT: ld 16'h1234, start SHL amt=10, assert rst after 3 cycles -> q=0, cn=0, busy=0, no done pulse, flag=4'b0010.
- ROL: ld 16'h8001, start op=000 amt=1 -> q=16'h0003, cn=1, done one cycle after busy.
- RCL wrap: cn=0, ld 16'h8000, op=001 amt=1 -> q=0, cn=1, z=1. Repeat with amt=17 from the same start -> q=16'h8000, cn=0.
- SAR: ld 16'h8004, op=110 amt=3 -> q=16'hF000, cn=1, n=1, parity=0.
- Over-range SHR: ld 16'h0001, op=101 amt=20 -> q=0, cn=0. done after edge E20 iterative, after E1 with SEQ_SHIFTER_BARREL_EN.
- Ignored inputs: during SHIFT pulse ld d=16'hFFFF and start -> no effect. op=111 amt=5 -> q unchanged, done after E0. start+ld same IDLE cycle -> q=d, no operation.

Source files
------------

// File: rtl/seq_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter_if
// Description : Controller-side bus of the sequential shift/rotate unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             ld;
    logic             ldc;
    logic [WIDTH-1:0] d;
    logic             cin;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] q;
    logic             cn;
    logic             busy;
    logic             done;
    logic [3:0]       flag;

    modport master (
        output ld, ldc, d, cin, start, op, amt,
        input  q, cn, busy, done, flag
    );

    modport slave (
        input  ld, ldc, d, cin, start, op, amt,
        output q, cn, busy, done, flag
    );
endinterface
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Multi-cycle shift/rotate unit with carry and status flags.
//               Define SEQ_SHIFTER_BARREL_EN for a single-cycle barrel datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  wire logic    clk,
    input  wire logic    rst,
    seq_shifter_if.slave bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [2:0] c_ROL = 3'b000;
    localparam logic [2:0] c_RCL = 3'b001;
    localparam logic [2:0] c_ROR = 3'b010;
    localparam logic [2:0] c_RCR = 3'b011;
    localparam logic [2:0] c_SHL = 3'b100;
    localparam logic [2:0] c_SHR = 3'b101;
    localparam logic [2:0] c_SAR = 3'b110;
    localparam logic [2:0] c_NOP = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_q;
    logic             r_cn;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_cn;
    logic             w_accept;

    // Any load in IDLE swallows a coincident start.
    assign w_accept = bus.start && !bus.ld && !bus.ldc;

`ifdef SEQ_SHIFTER_BARREL_EN
    int                 w_rot_k;
    int                 w_rc_k;
    logic [WIDTH:0]     w_cq;
    logic [WIDTH:0]     w_tmp;
    logic signed [WIDTH:0] w_sar;

    // Full amt-position result; rotates reduce modulo their period.
    always_comb begin
        w_rot_k   = int'(r_cnt) % WIDTH;
        w_rc_k    = int'(r_cnt) % (WIDTH + 1);
        w_cq      = {r_cn, r_q};
        w_tmp     = '0;
        w_sar     = '0;
        w_next_q  = r_q;
        w_next_cn = r_cn;
        case (r_op)
            c_ROL: begin
                w_next_q  = (r_q << w_rot_k) | (r_q >> (WIDTH - w_rot_k));
                w_next_cn = w_next_q[0];
            end
            c_ROR: begin
                w_next_q  = (r_q >> w_rot_k) | (r_q << (WIDTH - w_rot_k));
                w_next_cn = w_next_q[WIDTH-1];
            end
            c_RCL: begin
                w_tmp = (w_cq << w_rc_k) | (w_cq >> (WIDTH + 1 - w_rc_k));
                {w_next_cn, w_next_q} = w_tmp;
            end
            c_RCR: begin
                w_tmp = (w_cq >> w_rc_k) | (w_cq << (WIDTH + 1 - w_rc_k));
                {w_next_cn, w_next_q} = w_tmp;
            end
            c_SHL: begin
                w_tmp = {1'b0, r_q} << r_cnt;
                {w_next_cn, w_next_q} = w_tmp;
            end
            c_SHR: begin
                w_tmp = {r_q, 1'b0} >> r_cnt;
                {w_next_q, w_next_cn} = w_tmp;
            end
            c_SAR: begin
                w_sar = $signed({r_q, 1'b0}) >>> r_cnt;
                {w_next_q, w_next_cn} = w_sar;
            end
            default: ;
        endcase
    end
`else
    always_comb begin
        w_next_q  = r_q;
        w_next_cn = r_cn;
        case (r_op)
            c_ROL: begin
                w_next_q  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_next_cn = r_q[WIDTH-1];
            end
            c_RCL: {w_next_cn, w_next_q} = {r_q, r_cn};
            c_ROR: begin
                w_next_q  = {r_q[0], r_q[WIDTH-1:1]};
                w_next_cn = r_q[0];
            end
            c_RCR: {w_next_q, w_next_cn} = {r_cn, r_q};
            c_SHL: {w_next_cn, w_next_q} = {r_q, 1'b0};
            c_SHR: {w_next_q, w_next_cn} = {1'b0, r_q};
            c_SAR: {w_next_q, w_next_cn} = {r_q[WIDTH-1], r_q};
            default: ;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (bus.op == c_NOP || bus.amt == '0) begin
                        w_next_state = c_DONE;
                    end else begin
                        w_next_state = c_SHIFT;
                    end
                end
            end
`ifdef SEQ_SHIFTER_BARREL_EN
            c_SHIFT: w_next_state = c_DONE;
`else
            c_SHIFT: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_next_state = c_DONE;
                end
            end
`endif
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state == c_SHIFT);
        bus.done = (r_state == c_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_cn  <= 1'b0;
            r_op  <= c_ROL;
            r_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.ld) begin
                        r_q <= bus.d;
                    end
                    if (bus.ldc) begin
                        r_cn <= bus.cin;
                    end
                    if (w_accept) begin
                        r_op  <= bus.op;
                        r_cnt <= bus.amt;
                    end
                end
                c_SHIFT: begin
                    r_q   <= w_next_q;
                    r_cn  <= w_next_cn;
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.q    = r_q;
    assign bus.cn   = r_cn;
    assign bus.flag = {^r_q, r_q[WIDTH-1], (r_q == '0), r_cn};
endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shifter
// Description : Scoreboard bench for seq_shifter (WIDTH=16, CNT_W=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;
`ifdef SEQ_SHIFTER_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [15:0] q;
        logic        cn;
        int          cyc;
        logic        busy_prev;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    int   done_seen;
    logic prev_busy;
    logic prev_done;
    exp_t exp_q[$];

    seq_shifter_if #(.WIDTH(16), .CNT_W(5)) bus ();

    seq_shifter #(.WIDTH(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [3:0] flag_of(input logic [15:0] q, input logic cn);
        return {^q, q[15], (q == 16'h0), cn};
    endfunction

    // Monitor: every done pulse must match the oldest expectation.
    initial begin
        prev_busy = 1'b0;
        prev_done = 1'b0;
        done_seen = 0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.q), 32'hXXXX_XXXX);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_q"},    32'(bus.q),    32'(e.q));
                    check({e.name, "_cn"},   32'(bus.cn),   32'(e.cn));
                    check({e.name, "_flag"}, 32'(bus.flag), 32'(flag_of(e.q, e.cn)));
                    check({e.name, "_cyc"},  32'(cyc),      32'(e.cyc));
                    check({e.name, "_busyprev"}, 32'(prev_busy), 32'(e.busy_prev));
                end
                if (prev_done) check("done_two_cycles", 32'd1, 32'd0);
            end
            prev_busy = bus.busy;
            prev_done = bus.done;
        end
    end

    task automatic idle_inputs();
        bus.ld = 1'b0; bus.ldc = 1'b0; bus.d = 16'h0; bus.cin = 1'b0;
        bus.start = 1'b0; bus.op = 3'b000; bus.amt = 5'd0;
    endtask

    task automatic load(input logic l, input logic [15:0] dv, input logic lc, input logic c);
        @(negedge clk);
        bus.ld = l; bus.d = dv; bus.ldc = lc; bus.cin = c;
        @(negedge clk);
        bus.ld = 1'b0; bus.ldc = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
        check({nm, "_timeout"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic issue(input string nm, input logic [2:0] op, input logic [4:0] amt,
                         input logic [15:0] eq, input logic ecn, input bit inject);
        exp_t e;
        bit   zero_len;
        zero_len = (amt == 5'd0) || (op == 3'b111);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.amt = amt;
        @(posedge clk);
        #1;
        e.name      = nm;
        e.q         = eq;
        e.cn        = ecn;
        e.cyc       = zero_len ? cyc : (BARREL ? cyc + 1 : cyc + int'(amt));
        e.busy_prev = !zero_len;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        if (inject) begin
            // All of these must be ignored while the unit is in SHIFT.
            bus.ld = 1'b1; bus.d = 16'hFFFF; bus.ldc = 1'b1; bus.cin = 1'b1;
            bus.start = 1'b1; bus.op = 3'b000; bus.amt = 5'd1;
            @(negedge clk);
            idle_inputs();
        end
        wait_empty(nm);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_q",    32'(bus.q),    32'h0);
        check("rst_cn",   32'(bus.cn),   32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_flag", 32'(bus.flag), 32'h2);

        // Abort in the middle of SHL 10; barrel SHIFT lasts only one cycle.
        load(1'b1, 16'h1234, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b100; bus.amt = 5'd10;
        @(negedge clk);
        bus.start = 1'b0;
        if (!BARREL) repeat (2) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'h1);
        begin
            int d0;
            d0 = done_seen;
            rst = 1'b1;
            #1;
            check("abort_q",    32'(bus.q),    32'h0);
            check("abort_cn",   32'(bus.cn),   32'h0);
            check("abort_busy", 32'(bus.busy), 32'h0);
            check("abort_flag", 32'(bus.flag), 32'h2);
            @(negedge clk);
            rst = 1'b0;
            repeat (25) @(negedge clk);
            check("abort_no_done", 32'(done_seen), 32'(d0));
        end

        load(1'b1, 16'h8001, 1'b1, 1'b0); issue("rol1",   3'b000, 5'd1,  16'h0003, 1'b1, 1'b0);
        load(1'b1, 16'h8000, 1'b1, 1'b0); issue("rcl1",   3'b001, 5'd1,  16'h0000, 1'b1, 1'b0);
        load(1'b1, 16'h8000, 1'b1, 1'b0); issue("rcl17",  3'b001, 5'd17, 16'h8000, 1'b0, 1'b0);
        load(1'b1, 16'h0000, 1'b1, 1'b1); issue("rcl5",   3'b001, 5'd5,  16'h0010, 1'b0, 1'b0);
        load(1'b1, 16'h0000, 1'b1, 1'b1); issue("rcr1",   3'b011, 5'd1,  16'h8000, 1'b0, 1'b0);
        load(1'b1, 16'h8004, 1'b1, 1'b0); issue("sar3",   3'b110, 5'd3,  16'hF000, 1'b1, 1'b0);
        load(1'b1, 16'h8000, 1'b1, 1'b0); issue("sar31",  3'b110, 5'd31, 16'hFFFF, 1'b1, 1'b0);
        load(1'b1, 16'h0001, 1'b1, 1'b0); issue("shr20",  3'b101, 5'd20, 16'h0000, 1'b0, 1'b0);
        load(1'b1, 16'h0001, 1'b1, 1'b0); issue("shl16",  3'b100, 5'd16, 16'h0000, 1'b1, 1'b0);
        load(1'b1, 16'h0001, 1'b1, 1'b0); issue("shl17",  3'b100, 5'd17, 16'h0000, 1'b0, 1'b0);
        load(1'b1, 16'h8001, 1'b1, 1'b0); issue("rol16",  3'b000, 5'd16, 16'h8001, 1'b1, 1'b0);
        load(1'b1, 16'h0001, 1'b1, 1'b1); issue("ror20",  3'b010, 5'd20, 16'h1000, 1'b0, 1'b0);
        load(1'b1, 16'h00F0, 1'b1, 1'b0); issue("ror4_ign", 3'b010, 5'd4, 16'h000F, 1'b0, 1'b1);
        load(1'b0, 16'h0000, 1'b1, 1'b1); issue("nop5",   3'b111, 5'd5,  16'h000F, 1'b1, 1'b0);
        issue("amt0", 3'b100, 5'd0, 16'h000F, 1'b1, 1'b0);

        // start together with ld: load only, no operation.
        begin
            int d0;
            d0 = done_seen;
            @(negedge clk);
            bus.ld = 1'b1; bus.d = 16'hABCD; bus.start = 1'b1; bus.op = 3'b100; bus.amt = 5'd1;
            @(negedge clk);
            idle_inputs();
            check("startld_busy", 32'(bus.busy), 32'h0);
            repeat (4) @(negedge clk);
            check("startld_q",    32'(bus.q),    32'hABCD);
            check("startld_nodone", 32'(done_seen), 32'(d0));
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
